inst_fetch_decode: RTL and testbench
====================================

# inst_fetch_decode

Multi-cycle instruction fetch and decode front end for the 16-bit single-issue CPU. Reads one instruction word per fetch over the memory read handshake, holds it in an instruction register, and splits it into register indices, function code, jump target and an opcode-correct 16-bit immediate. The immediate ALU and the register file consume these fields directly. Consumers take instructions through a valid/ready handshake, and branches or jumps redirect the PC through a load port.

## Interface
- `WORD`, 16: datapath and instruction width.
- `RESET_PC`, 16'h0000: PC value after reset.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `readM`  out  1  memory read request.
- `address`  out  16  fetch address; equals `pc` whenever `readM`=1.
- `data`  in  16  memory read data; valid when `inputReady`=1.
- `inputReady`  in  1  memory read completion strobe; at most one per request.
- `pc_load`  in  1  redirect request.
- `pc_target`  in  16  redirect address; sampled when `pc_load`=1.
- `inst_valid`  out  1  decoded fields valid.
- `inst_ready`  in  1  consumer accepts the instruction.
- `opcode`  out  4  IR[15:12].
- `rs`, `rt`, `rd`  out  2 each  IR[11:10], IR[9:8], IR[7:6].
- `func_code`  out  6  IR[5:0].
- `target`  out  12  IR[11:0].
- `imm`  out  16  extended IR[7:0]; the extension rule is given under Operation.
- `pc_plus1`  out  16  address of the held instruction + 1.
- `halted`  out  1  an HLT instruction has been accepted.
- `num_inst`  out  16  count of accepted instructions.

## Operation
- FSM states: IDLE, FETCH, HOLD, HALT. The reset state is IDLE.
- **IDLE:** drives `readM`=0 and moves to FETCH on the next edge unconditionally.
- **FETCH:** drives `readM`=1 and `address`=`pc`.
  - On an edge with `inputReady`=1 and no redirect pending: IR<=`data`, `pc`<=`pc`+1 (16-bit wrap, 16'hFFFF->0), next state HOLD.
  - On an edge with `inputReady`=1 and a redirect pending: discard `data`, `pc`<=saved target, clear pending, next state IDLE.
- **HOLD:** drives `inst_valid`=1 with all decode outputs stable from IR.
  - `inst_ready`=1: `num_inst`<=`num_inst`+1 (wraps). Next state is HALT if the instruction is HLT (opcode 4'hF, func 6'd29), otherwise FETCH.
  - `pc_load`=1 with `inst_ready`=0: drop the instruction, `pc`<=`pc_target`, next state FETCH.
  - `pc_load`=1 with `inst_ready`=1: the instruction is counted as accepted and `pc`<=`pc_target`.
- **HALT:** `readM`=0, `inst_valid`=0, `halted`=1. `pc_load` is ignored. Only `reset` leaves HALT.
- `pc_load` during FETCH is saved in a pending register together with the target. A later `pc_load` overwrites the saved target. The outstanding read always completes before the redirect takes effect.
- `pc_load` in IDLE: `pc`<=`pc_target` directly.
- Immediate extension:
  - ADI (4'h4), LWD (4'h7), SWD (4'h8), BNE/BEQ/BGZ/BLZ (4'h0–4'h3): sign-extend IR[7:0].
  - ORI (4'h5) and LHI (4'h6): zero-extend IR[7:0].
  - All other opcodes: zero-extend IR[7:0].
- `pc_plus1` is the `pc` value after the increment at fetch, i.e. the address following the held instruction.

## Timing
- Reset values: `readM`=0, `address`=`RESET_PC`, `inst_valid`=0, `halted`=0, `num_inst`=0, IR=16'h0000 (all decode outputs 0, `imm`=0), pending redirect cleared.
- `readM` rises on the first edge after `reset` falls.
- Fetch-to-valid latency: `inst_valid` rises on the edge that samples `inputReady`=1. The decode outputs are valid in the same cycle.
- With a zero-wait memory (inputReady asserted in the first FETCH cycle) and a consumer holding `inst_ready`=1, the block sustains one instruction every 2 cycles.
- All outputs are decoded from registered state or IR. There is no combinational path from any input to any output.
- Asserting `reset` mid-fetch drops `readM` immediately (asynchronous). A late `inputReady` after reset is ignored because the FSM is in IDLE.

## Structure
- Opcode and function-code constants (ADI/ORI/LHI/LWD/SWD/branch/HLT values) and the state encoding belong in the shared opcode definitions file used by the ALU and control.
- Natural sub-module: `imm_extend`, a combinational 8→16 extender selected by opcode. The FSM, PC, IR and counter stay in the top.

## Test plan
- **Reset and single fetch:** release reset with `inputReady` returning 16'h4A05 after 3 wait cycles, `inst_ready`=1. Expected: `address`=0, then `opcode`=4, `rs`=2, `rt`=2, `imm`=16'h0005, `pc_plus1`=1, `num_inst`=1.
- **Immediate extension:** fetch ADI 16'h40FF -> `imm`=16'hFFFF. Fetch ORI 16'h50FF -> `imm`=16'h00FF. Fetch LHI 16'h6080 -> `imm`=16'h0080.
- **Backpressure:** hold `inst_ready`=0 for 5 cycles. Expected: `inst_valid` stays 1, outputs stable, `readM`=0, `num_inst` unchanged.
- **Redirect during FETCH:** pulse `pc_load` with `pc_target`=16'h0020 while waiting on memory. Expected: the returned word is discarded, `inst_valid` stays 0, and the next `address`=16'h0020.
- **Simultaneous accept and redirect in HOLD:** assert both, `pc_target`=16'h0100. Expected: `num_inst`+1 and next fetch `address`=16'h0100. Also: `pc` at 16'hFFFF fetches and wraps to 0.
- **HLT:** fetch 16'hF01D and accept. Expected: `halted`=1, `readM` stays 0 for 20 cycles, `pc_load` is ignored, and only reset clears the state.

Source files
------------

// File: rtl/inst_fetch_decode_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_decode_pkg
// Shared opcode definitions for the 16-bit single-issue CPU front end.
// Holds the opcode and function-code values used by the ALU and control,
// the fetch/decode FSM state encoding, and small decode helpers.
// Ports: none (package).
// ---------------------------------------------------------------------------
package inst_fetch_decode_pkg;

    localparam int INST_W = 16;

    // Opcodes in IR[15:12]
    localparam logic [3:0] OP_BNE = 4'h0;
    localparam logic [3:0] OP_BEQ = 4'h1;
    localparam logic [3:0] OP_BGZ = 4'h2;
    localparam logic [3:0] OP_BLZ = 4'h3;
    localparam logic [3:0] OP_ADI = 4'h4;
    localparam logic [3:0] OP_ORI = 4'h5;
    localparam logic [3:0] OP_LHI = 4'h6;
    localparam logic [3:0] OP_LWD = 4'h7;
    localparam logic [3:0] OP_SWD = 4'h8;
    localparam logic [3:0] OP_RTYPE = 4'hF;

    // Function codes in IR[5:0] for R-type instructions
    localparam logic [5:0] FUNC_HLT = 6'd29;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    // Arithmetic, memory-offset and branch immediates are signed; logical
    // immediates (ORI, LHI) and everything else are zero-extended.
    function automatic logic imm_is_signed(input logic [3:0] op);
        logic s;
        s = 1'b0;
        case (op)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ,
            OP_ADI, OP_LWD, OP_SWD: s = 1'b1;
            default:                s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic is_hlt(input logic [INST_W-1:0] inst);
        return (inst[15:12] == OP_RTYPE) && (inst[5:0] == FUNC_HLT);
    endfunction

endpackage

// File: rtl/inst_fetch_decode_imm_extend.sv
// ---------------------------------------------------------------------------
// imm_extend
// Combinational 8-to-16 bit immediate extender. The opcode chooses between
// sign extension and zero extension of the low instruction byte.
// Ports:
//   opcode  in   4   instruction opcode (IR[15:12])
//   imm8    in   8   raw immediate (IR[7:0])
//   imm     out  16  extended immediate
// ---------------------------------------------------------------------------
module imm_extend
    import inst_fetch_decode_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [7:0]  imm8,
    output logic [15:0] imm
);

    assign imm = imm_is_signed(opcode) ? {{8{imm8[7]}}, imm8} : {8'h00, imm8};

endmodule

// File: rtl/inst_fetch_decode.sv
// ---------------------------------------------------------------------------
// inst_fetch_decode
// Multi-cycle instruction fetch and decode front end. Fetches one word per
// memory read handshake into the instruction register, presents the decoded
// fields to the consumer through a valid/ready handshake, and accepts PC
// redirects from branch/jump resolution.
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   readM, address       memory read request and fetch address (= pc)
//   data, inputReady     memory read data and completion strobe
//   pc_load, pc_target   redirect request and new PC
//   inst_valid           decoded fields valid (held instruction present)
//   inst_ready           consumer accepts the held instruction
//   opcode/rs/rt/rd/func_code/target/imm   decoded fields of IR
//   pc_plus1             address following the held instruction
//   halted               an HLT instruction has been accepted
//   num_inst             count of accepted instructions
// Decode fields assume a 16-bit instruction word.
// ---------------------------------------------------------------------------
module inst_fetch_decode
    import inst_fetch_decode_pkg::*;
#(
    parameter int              WORD     = 16,
    parameter logic [WORD-1:0] RESET_PC = '0
)
(
    input  logic            clk,
    input  logic            reset,
    output logic            readM,
    output logic [WORD-1:0] address,
    input  logic [WORD-1:0] data,
    input  logic            inputReady,
    input  logic            pc_load,
    input  logic [WORD-1:0] pc_target,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [3:0]      opcode,
    output logic [1:0]      rs,
    output logic [1:0]      rt,
    output logic [1:0]      rd,
    output logic [5:0]      func_code,
    output logic [11:0]     target,
    output logic [15:0]     imm,
    output logic [WORD-1:0] pc_plus1,
    output logic            halted,
    output logic [15:0]     num_inst
);

    fetch_state_t    state, state_next;
    logic [WORD-1:0] pc, pc_next;
    logic [WORD-1:0] ir, ir_next;
    logic [WORD-1:0] pc_plus1_q, pc_plus1_next;
    logic            pend, pend_next;
    logic [WORD-1:0] pend_tgt, pend_tgt_next;
    logic [15:0]     count, count_next;

    // State, PC, IR and counter registers; reset clears everything so that a
    // late inputReady after reset lands in IDLE and is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            pc_plus1_q <= '0;
            pend       <= 1'b0;
            pend_tgt   <= '0;
            count      <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ir         <= ir_next;
            pc_plus1_q <= pc_plus1_next;
            pend       <= pend_next;
            pend_tgt   <= pend_tgt_next;
            count      <= count_next;
        end
    end

    // Next-state logic. A redirect arriving while a read is outstanding is
    // parked in pend/pend_tgt (newest target wins) and applied only when the
    // read completes; a redirect in the very completion cycle counts too.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        ir_next       = ir;
        pc_plus1_next = pc_plus1_q;
        pend_next     = pend;
        pend_tgt_next = pend_tgt;
        count_next    = count;

        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
                if (pc_load) begin
                    pc_next = pc_target;
                end
            end

            S_FETCH: begin
                if (pc_load) begin
                    pend_next     = 1'b1;
                    pend_tgt_next = pc_target;
                end
                if (inputReady) begin
                    if (pend || pc_load) begin
                        pc_next    = pc_load ? pc_target : pend_tgt;
                        pend_next  = 1'b0;
                        state_next = S_IDLE;
                    end else begin
                        ir_next       = data;
                        pc_next       = pc + WORD'(1);
                        pc_plus1_next = pc + WORD'(1);
                        state_next    = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (inst_ready) begin
                    count_next = count + 16'd1;
                    if (pc_load) begin
                        pc_next = pc_target;
                    end
                    state_next = is_hlt(ir) ? S_HALT : S_FETCH;
                end else if (pc_load) begin
                    pc_next    = pc_target;
                    state_next = S_FETCH;
                end
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign readM      = (state == S_FETCH);
    assign address    = pc;
    assign inst_valid = (state == S_HOLD);
    assign halted     = (state == S_HALT);
    assign num_inst   = count;
    assign pc_plus1   = pc_plus1_q;

    assign opcode    = ir[15:12];
    assign rs        = ir[11:10];
    assign rt        = ir[9:8];
    assign rd        = ir[7:6];
    assign func_code = ir[5:0];
    assign target    = ir[11:0];

    imm_extend u_imm_extend (
        .opcode (ir[15:12]),
        .imm8   (ir[7:0]),
        .imm    (imm)
    );

endmodule

// File: tb/tb_inst_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_decode
// Scoreboard bench for inst_fetch_decode. The driver plays memory and
// consumer, pushing the expected decode of every word that should reach the
// consumer; a monitor pops an entry whenever a new instruction is presented
// and checks all decode outputs while it is held.
// ---------------------------------------------------------------------------
module tb_inst_fetch_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        readM;
    logic [15:0] address;
    logic [15:0] data;
    logic        inputReady;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [3:0]  opcode;
    logic [1:0]  rs, rt, rd;
    logic [5:0]  func_code;
    logic [11:0] target;
    logic [15:0] imm;
    logic [15:0] pc_plus1;
    logic        halted;
    logic [15:0] num_inst;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] next_addr;
        logic [15:0] count;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_addr;
    logic [15:0] model_count;

    always #5 clk = ~clk;

    inst_fetch_decode #(.WORD(16), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .readM      (readM),
        .address    (address),
        .data       (data),
        .inputReady (inputReady),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .func_code  (func_code),
        .target     (target),
        .imm        (imm),
        .pc_plus1   (pc_plus1),
        .halted     (halted),
        .num_inst   (num_inst)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference immediate: signed for branches, ADI, LWD, SWD; zero otherwise.
    function automatic logic [15:0] ref_imm(input logic [15:0] w);
        logic [3:0] op;
        op = w[15:12];
        if (op <= 4'h4 || op == 4'h7 || op == 4'h8)
            return {{8{w[7]}}, w[7:0]};
        return {8'h00, w[7:0]};
    endfunction

    // Monitor: a new instruction is presented when inst_valid rises.
    exp_t cur;
    bit   have_cur   = 1'b0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            have_cur   = 1'b0;
        end else begin
            if (inst_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_valid: got instruction %h expected none", {opcode, rs, rt, rd, func_code});
                    have_cur = 1'b0;
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (inst_valid && have_cur) begin
                checkOutput("opcode",    opcode,    cur.word[15:12]);
                checkOutput("rs",        rs,        cur.word[11:10]);
                checkOutput("rt",        rt,        cur.word[9:8]);
                checkOutput("rd",        rd,        cur.word[7:6]);
                checkOutput("func_code", func_code, cur.word[5:0]);
                checkOutput("target",    target,    cur.word[11:0]);
                checkOutput("imm",       imm,       ref_imm(cur.word));
                checkOutput("pc_plus1",  pc_plus1,  cur.next_addr);
                checkOutput("num_inst",  num_inst,  cur.count);
            end
            prev_valid = inst_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitFetch();
        for (int i = 0; i < 8 && !readM; i++) tick();
        checkOutput("readM_timeout", readM, 1);
        checkOutput("fetch_addr", address, exp_addr);
    endtask

    // One fetch transaction. nredir redirect pulses during the memory wait
    // (the second overwrites the first); mode 0 accept, 1 accept+redirect,
    // 2 drop via redirect; hold_tgt is the redirect target for modes 1 and 2.
    task automatic applyStimulus(input logic [15:0] word, input int waits,
                                 input int nredir, input logic [15:0] rtgt,
                                 input int bp, input int mode,
                                 input logic [15:0] hold_tgt,
                                 output bit was_redir);
        logic [15:0] fa;
        logic [15:0] final_tgt;
        int          w;
        was_redir = 1'b0;
        final_tgt = '0;
        w = (waits < nredir) ? nredir : waits;
        waitFetch();
        fa = exp_addr;
        for (int i = 0; i < w; i++) begin
            if (i < nredir) begin
                pc_load   = 1'b1;
                pc_target = (i == 0) ? rtgt : (rtgt ^ 16'h0F0F);
                final_tgt = pc_target;
                was_redir = 1'b1;
            end
            tick();
            pc_load = 1'b0;
        end
        data       = word;
        inputReady = 1'b1;
        if (!was_redir) sb.push_back('{word, fa + 16'd1, model_count});
        tick();
        inputReady = 1'b0;
        data       = 16'($urandom);
        if (was_redir) begin
            checkOutput("discard_valid", inst_valid, 0);
            exp_addr = final_tgt;
            return;
        end
        checkOutput("hold_valid", inst_valid, 1);
        for (int i = 0; i < bp; i++) begin
            inst_ready = 1'b0;
            checkOutput("bp_readM", readM, 0);
            checkOutput("bp_valid", inst_valid, 1);
            tick();
        end
        case (mode)
            1: begin
                inst_ready = 1'b1;
                pc_load    = 1'b1;
                pc_target  = hold_tgt;
                tick();
                model_count = model_count + 16'd1;
                exp_addr    = hold_tgt;
            end
            2: begin
                inst_ready = 1'b0;
                pc_load    = 1'b1;
                pc_target  = hold_tgt;
                tick();
                exp_addr = hold_tgt;
            end
            default: begin
                inst_ready = 1'b1;
                tick();
                model_count = model_count + 16'd1;
                exp_addr    = fa + 16'd1;
            end
        endcase
        inst_ready = 1'b0;
        pc_load    = 1'b0;
        checkOutput("num_inst_after", num_inst, model_count);
        checkOutput("valid_after", inst_valid, 0);
    endtask

    task automatic idleLoad(input logic [15:0] tgt);
        pc_load   = 1'b1;
        pc_target = tgt;
        tick();
        pc_load  = 1'b0;
        exp_addr = tgt;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          r;
        logic [15:0] word;
        int          sel;

        reset = 1'b1; data = '0; inputReady = 1'b0; pc_load = 1'b0;
        pc_target = '0; inst_ready = 1'b0;
        exp_addr = 16'h0000; model_count = 16'h0000;
        repeat (2) @(negedge clk);

        checkOutput("rst_readM",    readM,      0);
        checkOutput("rst_address",  address,    16'h0000);
        checkOutput("rst_valid",    inst_valid, 0);
        checkOutput("rst_halted",   halted,     0);
        checkOutput("rst_num_inst", num_inst,   0);
        checkOutput("rst_imm",      imm,        0);
        checkOutput("rst_opcode",   opcode,     0);
        reset = 1'b0;

        // Single fetch with three wait cycles
        applyStimulus(16'h4A05, 3, 0, 16'h0, 0, 0, 16'h0, r);

        // Immediate extension cases
        applyStimulus(16'h40FF, 0, 0, 16'h0, 0, 0, 16'h0, r);
        applyStimulus(16'h50FF, 0, 0, 16'h0, 0, 0, 16'h0, r);
        applyStimulus(16'h6080, 0, 0, 16'h0, 0, 0, 16'h0, r);
        applyStimulus(16'h7A80, 1, 0, 16'h0, 0, 0, 16'h0, r);

        // Backpressure for five cycles
        applyStimulus(16'h2B9C, 1, 0, 16'h0, 5, 0, 16'h0, r);

        // Redirect during FETCH, then an overwritten redirect
        applyStimulus(16'h1234, 2, 1, 16'h0020, 0, 0, 16'h0, r);
        applyStimulus(16'h3456, 3, 2, 16'h0300, 0, 0, 16'h0, r);
        applyStimulus(16'h0181, 0, 0, 16'h0, 0, 0, 16'h0, r);

        // Simultaneous accept and redirect in HOLD
        applyStimulus(16'h8F7E, 0, 0, 16'h0, 1, 1, 16'h0100, r);

        // Drop to 16'hFFFF, then fetch there and wrap to 0
        applyStimulus(16'hA5A5, 1, 0, 16'h0, 0, 2, 16'hFFFF, r);
        applyStimulus(16'h3C80, 0, 0, 16'h0, 0, 0, 16'h0, r);
        applyStimulus(16'h5001, 0, 0, 16'h0, 0, 0, 16'h0, r);

        // Redirect discard then a direct load while idle
        applyStimulus(16'h4444, 1, 1, 16'h0040, 0, 0, 16'h0, r);
        idleLoad(16'h0077);

        // Reset mid-fetch; a late inputReady in IDLE is ignored
        waitFetch();
        reset = 1'b1;
        #1;
        checkOutput("async_rst_readM", readM,   0);
        checkOutput("async_rst_addr",  address, 16'h0000);
        @(negedge clk);
        reset      = 1'b0;
        data       = 16'h4321;
        inputReady = 1'b1;
        tick();
        inputReady = 1'b0;
        checkOutput("late_ready_valid", inst_valid, 0);
        checkOutput("late_ready_readM", readM,      1);
        checkOutput("late_ready_addr",  address,    16'h0000);
        checkOutput("late_ready_num",   num_inst,   0);
        model_count = 16'h0000;
        exp_addr    = 16'h0000;

        // Randomized transactions
        for (int n = 0; n < 150; n++) begin
            word = 16'($urandom);
            if (word[15:12] == 4'hF && word[5:0] == 6'd29) word[0] = ~word[0];
            sel = $urandom_range(0, 9);
            applyStimulus(word, $urandom_range(0, 3),
                          ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0,
                          16'($urandom), $urandom_range(0, 3),
                          (sel == 0) ? 2 : ((sel == 1) ? 1 : 0),
                          16'($urandom), r);
            if (r && $urandom_range(0, 1) == 1) idleLoad(16'($urandom));
        end

        // HLT: accept, then stay halted with pc_load ignored
        applyStimulus(16'hF01D, 1, 0, 16'h0, 0, 0, 16'h0, r);
        for (int i = 0; i < 20; i++) begin
            checkOutput("halt_readM",  readM,      0);
            checkOutput("halt_flag",   halted,     1);
            checkOutput("halt_valid",  inst_valid, 0);
            checkOutput("halt_addr",   address,    exp_addr);
            if (i == 5) begin
                pc_load   = 1'b1;
                pc_target = 16'h1234;
            end
            tick();
            pc_load = 1'b0;
        end

        // Only reset leaves HALT
        reset = 1'b1;
        #1;
        checkOutput("unhalt_flag",  halted,   0);
        checkOutput("unhalt_num",   num_inst, 0);
        checkOutput("unhalt_addr",  address,  16'h0000);
        @(negedge clk);
        reset       = 1'b0;
        model_count = 16'h0000;
        exp_addr    = 16'h0000;
        applyStimulus(16'h4BFE, 2, 0, 16'h0, 0, 0, 16'h0, r);

        tick();
        checkOutput("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
